// File: rtl/legv8_pkg.sv
// Shared encodings, state/class enums and per-state control table
// for the multi-cycle LEGv8 control path.
package legv8_pkg;

    localparam int ALU_W = 3;

    localparam logic [ALU_W-1:0] ALU_AND   = 3'b000;
    localparam logic [ALU_W-1:0] ALU_ORR   = 3'b001;
    localparam logic [ALU_W-1:0] ALU_PASSB = 3'b100;
    localparam logic [ALU_W-1:0] ALU_ADD   = 3'b101;
    localparam logic [ALU_W-1:0] ALU_SUB   = 3'b110;
    localparam logic [ALU_W-1:0] ALU_MOVK  = 3'b111;

    localparam logic [1:0] SRCB_REG    = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;

    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_MOVK = 11'b11110010100;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXEC_R    = 4'd3,
        S_EXEC_ADDR = 4'd4,
        S_MEM_RD    = 4'd5,
        S_MEM_WR    = 4'd6,
        S_WB_ALU    = 4'd7,
        S_WB_MEM    = 4'd8,
        S_BRANCH    = 4'd9,
        S_TRAP      = 4'd10
    } state_e;

    typedef enum logic [2:0] {
        C_ILLEGAL = 3'd0,
        C_RTYPE   = 3'd1,
        C_MOVK    = 3'd2,
        C_LOAD    = 3'd3,
        C_STORE   = 3'd4,
        C_B       = 3'd5,
        C_CBZ     = 3'd6,
        C_CBNZ    = 3'd7
    } iclass_e;

    // fetch_wr and br_z/br_nz are qualified later by mem_ready / alu_zero
    typedef struct packed {
        logic             mem_req;
        logic             mem_read;
        logic             mem_write;
        logic             i_or_d;
        logic             fetch_wr;
        logic             pc_uncond;
        logic             br_z;
        logic             br_nz;
        logic             reg_write;
        logic             mem_to_reg;
        logic             reg2loc;
        logic             alu_src_a;
        logic [1:0]       alu_src_b;
        logic [ALU_W-1:0] alu_op;
        logic [1:0]       pc_src;
        logic             trap;
    } ctrl_t;

    function automatic ctrl_t ctrl_for(
        state_e           s,
        iclass_e          c,
        logic [ALU_W-1:0] op
    );
        ctrl_t o;
        o = '0;
        unique case (s)
            S_FETCH: begin
                o.mem_req   = 1'b1;
                o.mem_read  = 1'b1;
                o.fetch_wr  = 1'b1;
                o.alu_src_b = SRCB_FOUR;
                o.alu_op    = ALU_ADD;
                o.pc_src    = PCSRC_ALU;
            end
            S_DECODE: begin
                o.alu_src_b = SRCB_IMM_SH;
                o.alu_op    = ALU_ADD;
            end
            S_EXEC_R: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = (c == C_MOVK) ? SRCB_IMM : SRCB_REG;
                o.alu_op    = op;
            end
            S_EXEC_ADDR: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = SRCB_IMM;
                o.alu_op    = ALU_ADD;
                o.reg2loc   = (c == C_STORE);
            end
            S_MEM_RD: begin
                o.mem_req  = 1'b1;
                o.mem_read = 1'b1;
                o.i_or_d   = 1'b1;
            end
            S_MEM_WR: begin
                o.mem_req   = 1'b1;
                o.mem_write = 1'b1;
                o.i_or_d    = 1'b1;
            end
            S_WB_ALU: o.reg_write = 1'b1;
            S_WB_MEM: begin
                o.reg_write  = 1'b1;
                o.mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                o.pc_src = PCSRC_ALUOUT;
                if (c == C_B) begin
                    o.pc_uncond = 1'b1;
                end else begin
                    o.reg2loc   = 1'b1;
                    o.alu_src_a = 1'b1;
                    o.alu_src_b = SRCB_REG;
                    o.alu_op    = ALU_PASSB;
                    o.br_z      = (c == C_CBZ);
                    o.br_nz     = (c == C_CBNZ);
                end
            end
            S_TRAP:  o.trap = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/legv8_multicycle_ctrl_if.sv
// Shared instruction/data memory port between the control FSM
// (master) and the variable-latency memory (slave).
interface legv8_multicycle_ctrl_if;

    logic mem_req;
    logic mem_read;
    logic mem_write;
    logic i_or_d;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_read,
        output mem_write,
        output i_or_d,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_read,
        input  mem_write,
        input  i_or_d,
        output mem_ready
    );

endinterface

// File: rtl/legv8_opdecode.sv
// Opcode classifier: maps IR[31:21] to an instruction class and
// the ALU operation used in the execute step.
module legv8_opdecode
    import legv8_pkg::*;
#(
    parameter int OPCODE_W = 11
) (
    input  logic [OPCODE_W-1:0] opcode,
    output iclass_e             cls_o,
    output logic [ALU_W-1:0]    alu_op_o
);

    logic [5:0] top6;
    logic [7:0] top8;
    logic is_b, is_cbz, is_cbnz;
    logic is_and, is_add, is_orr, is_sub;
    logic is_movk, is_stur, is_ldur;

    assign top6    = opcode[OPCODE_W-1 -: 6];
    assign top8    = opcode[OPCODE_W-1 -: 8];
    assign is_b    = (top6 == OP_B);
    assign is_cbz  = (top8 == OP_CBZ);
    assign is_cbnz = (top8 == OP_CBNZ);
    assign is_and  = (opcode == OPCODE_W'(OP_AND));
    assign is_add  = (opcode == OPCODE_W'(OP_ADD));
    assign is_orr  = (opcode == OPCODE_W'(OP_ORR));
    assign is_sub  = (opcode == OPCODE_W'(OP_SUB));
    assign is_movk = (opcode == OPCODE_W'(OP_MOVK));
    assign is_stur = (opcode == OPCODE_W'(OP_STUR));
    assign is_ldur = (opcode == OPCODE_W'(OP_LDUR));

    always_comb begin
        cls_o    = C_ILLEGAL;
        alu_op_o = ALU_ADD;
        unique case (1'b1)
            is_and: begin
                cls_o    = C_RTYPE;
                alu_op_o = ALU_AND;
            end
            is_add: begin
                cls_o    = C_RTYPE;
                alu_op_o = ALU_ADD;
            end
            is_orr: begin
                cls_o    = C_RTYPE;
                alu_op_o = ALU_ORR;
            end
            is_sub: begin
                cls_o    = C_RTYPE;
                alu_op_o = ALU_SUB;
            end
            is_movk: begin
                cls_o    = C_MOVK;
                alu_op_o = ALU_MOVK;
            end
            is_stur: cls_o = C_STORE;
            is_ldur: cls_o = C_LOAD;
            is_b:    cls_o = C_B;
            is_cbz: begin
                cls_o    = C_CBZ;
                alu_op_o = ALU_PASSB;
            end
            is_cbnz: begin
                cls_o    = C_CBNZ;
                alu_op_o = ALU_PASSB;
            end
            default: begin
                cls_o    = C_ILLEGAL;
                alu_op_o = ALU_ADD;
            end
        endcase
    end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// Moore control FSM for the multi-cycle LEGv8 datapath with
// variable-latency memory handshake, timeout and illegal-op traps.
module legv8_multicycle_ctrl
    import legv8_pkg::*;
#(
    parameter int OPCODE_W    = 11,
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            instr,
    input  logic                   alu_zero,
    legv8_multicycle_ctrl_if.master mem,
    output logic                   ir_write,
    output logic                   pc_write,
    output logic                   reg_write,
    output logic                   mem_to_reg,
    output logic                   reg2loc,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [ALUOP_W-1:0]     alu_op,
    output logic [1:0]             pc_src,
    output logic                   trap,
    output logic [3:0]             state_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    iclass_e           cls_q, cls_d;
    logic [ALU_W-1:0]  aluop_q, aluop_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    ctrl_t             out_q, out_d;

    iclass_e          dec_cls;
    logic [ALU_W-1:0] dec_op;
    logic             in_wait;
    logic             timeout;
    logic             entering;
    logic             unused_instr;

    legv8_opdecode #(
        .OPCODE_W (OPCODE_W)
    ) u_dec (
        .opcode   (instr[31 -: OPCODE_W]),
        .cls_o    (dec_cls),
        .alu_op_o (dec_op)
    );

    assign unused_instr = ^instr[31-OPCODE_W:0];

    assign in_wait = (state_q == S_FETCH) ||
                     (state_q == S_MEM_RD) ||
                     (state_q == S_MEM_WR);
    // a ready in the last allowed cycle still completes the access
    assign timeout = in_wait && !mem.mem_ready &&
                     (wait_q == WAIT_LAST);

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        aluop_d = aluop_q;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (mem.mem_ready)
                    state_d = S_DECODE;
                else if (timeout)
                    state_d = S_TRAP;
            end
            S_DECODE: begin
                cls_d   = dec_cls;
                aluop_d = dec_op;
                unique case (dec_cls)
                    C_RTYPE, C_MOVK:    state_d = S_EXEC_R;
                    C_LOAD, C_STORE:    state_d = S_EXEC_ADDR;
                    C_B, C_CBZ, C_CBNZ: state_d = S_BRANCH;
                    default:            state_d = S_TRAP;
                endcase
            end
            S_EXEC_R: state_d = S_WB_ALU;
            S_EXEC_ADDR: begin
                state_d = (cls_q == C_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                if (mem.mem_ready)
                    state_d = S_WB_MEM;
                else if (timeout)
                    state_d = S_TRAP;
            end
            S_MEM_WR: begin
                if (mem.mem_ready)
                    state_d = S_FETCH;
                else if (timeout)
                    state_d = S_TRAP;
            end
            S_WB_ALU: state_d = S_FETCH;
            S_WB_MEM: state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_TRAP;
        endcase
    end

    assign entering = (state_d != state_q) &&
                      ((state_d == S_FETCH) ||
                       (state_d == S_MEM_RD) ||
                       (state_d == S_MEM_WR));

    always_comb begin
        wait_d = wait_q;
        if (entering)
            wait_d = '0;
        else if (in_wait && !mem.mem_ready && wait_q != WAIT_MAX)
            wait_d = wait_q + WAIT_W'(1);
    end

    assign out_d = ctrl_for(state_d, cls_d, aluop_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cls_q   <= C_ILLEGAL;
            aluop_q <= '0;
            wait_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            aluop_q <= aluop_d;
            wait_q  <= wait_d;
            out_q   <= out_d;
        end
    end

    assign mem.mem_req   = out_q.mem_req;
    assign mem.mem_read  = out_q.mem_read;
    assign mem.mem_write = out_q.mem_write;
    assign mem.i_or_d    = out_q.i_or_d;

    assign ir_write   = out_q.fetch_wr & mem.mem_ready;
    assign pc_write   = (out_q.fetch_wr & mem.mem_ready) |
                        out_q.pc_uncond |
                        (out_q.br_z & alu_zero) |
                        (out_q.br_nz & ~alu_zero);
    assign reg_write  = out_q.reg_write;
    assign mem_to_reg = out_q.mem_to_reg;
    assign reg2loc    = out_q.reg2loc;
    assign alu_src_a  = out_q.alu_src_a;
    assign alu_src_b  = out_q.alu_src_b;
    assign alu_op     = ALUOP_W'(out_q.alu_op);
    assign pc_src     = out_q.pc_src;
    assign trap       = out_q.trap;
    assign state_o    = state_q;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Directed, table-driven bench for legv8_multicycle_ctrl with
// hand-written timeout and asynchronous-reset sequences.
module tb_legv8_multicycle_ctrl;
    import legv8_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       req, rd, wr, iod, irw, pcw, rw, m2r, r2l, sa;
        logic [1:0] sb;
        logic [2:0] op;
        logic [1:0] ps;
        logic       trp;
    } outs_t;

    typedef struct {
        logic [31:0] instr;
        logic        rdy;
        logic        z;
        outs_t       exp;
        string       tag;
    } vec_t;

    localparam logic [31:0] I_ADD  = {11'b10001011000, 21'h00443};
    localparam logic [31:0] I_SUB  = {11'b11001011000, 21'h00822};
    localparam logic [31:0] I_AND  = {11'b10001010000, 21'h00101};
    localparam logic [31:0] I_ORR  = {11'b10101010000, 21'h00205};
    localparam logic [31:0] I_MOVK = {11'b11110010100, 21'h1ABCD};
    localparam logic [31:0] I_LDUR = {11'b11111000010, 21'h00C41};
    localparam logic [31:0] I_STUR = {11'b11111000000, 21'h00C42};
    localparam logic [31:0] I_B    = {6'b000101, 26'h0000010};
    localparam logic [31:0] I_CBZ  = {8'b10110100, 24'h000083};
    localparam logic [31:0] I_CBNZ = {8'b10110101, 24'h000083};
    localparam logic [31:0] I_BAD  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        alu_zero;
    logic        ir_write, pc_write, reg_write, mem_to_reg, reg2loc;
    logic        alu_src_a, trap;
    logic [1:0]  alu_src_b, pc_src;
    logic [2:0]  alu_op;
    logic [3:0]  state_o;

    legv8_multicycle_ctrl_if mif ();

    legv8_multicycle_ctrl #(
        .OPCODE_W    (11),
        .ALUOP_W     (3),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .alu_zero   (alu_zero),
        .mem        (mif.master),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .reg2loc    (reg2loc),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .trap       (trap),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    vec_t vecs[$];
    outs_t act;

    assign act = {state_o, mif.mem_req, mif.mem_read, mif.mem_write,
                  mif.i_or_d, ir_write, pc_write, reg_write,
                  mem_to_reg, reg2loc, alu_src_a, alu_src_b, alu_op,
                  pc_src, trap};

    outs_t IDLE0, FET_W, FET_R, DEC, WBA, WBM, TRP;
    outs_t EX_ADD, EX_SUB, EX_AND, EX_ORR, EX_MOVK;
    outs_t EA_LD, EA_ST, MRD, MWR, BR_B, BR_CT, BR_CN;

    // f = {req, rd, wr, iod, irw, pcw, rw, m2r, r2l, sa}
    function automatic outs_t mk(logic [3:0] st, logic [9:0] f,
                                 logic [1:0] sb, logic [2:0] op,
                                 logic [1:0] ps, logic trp);
        return {st, f, sb, op, ps, trp};
    endfunction

    task automatic add(string tag, logic [31:0] i, logic r,
                       logic z, outs_t e);
        vecs.push_back('{i, r, z, e, tag});
    endtask

    task automatic check(string tag, outs_t e);
        tests++;
        if (act !== e) begin
            fails++;
            $display("FAIL %s: got st=%0d ctl=%b, want st=%0d ctl=%b",
                     tag, act.st, act[17:0], e.st, e[17:0]);
        end
    endtask

    task automatic step(string tag, logic [31:0] i, logic r,
                        logic z, outs_t e);
        instr         = i;
        mif.mem_ready = r;
        alu_zero      = z;
        #1;
        check(tag, e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        instr         = '0;
        alu_zero      = 1'b0;
        mif.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("in_reset", IDLE0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        IDLE0   = mk(S_IDLE,      10'b0000000000, 2'd0, 3'b000, 2'd0, 1'b0);
        FET_W   = mk(S_FETCH,     10'b1100000000, 2'd1, 3'b101, 2'd0, 1'b0);
        FET_R   = mk(S_FETCH,     10'b1100110000, 2'd1, 3'b101, 2'd0, 1'b0);
        DEC     = mk(S_DECODE,    10'b0000000000, 2'd3, 3'b101, 2'd0, 1'b0);
        EX_ADD  = mk(S_EXEC_R,    10'b0000000001, 2'd0, 3'b101, 2'd0, 1'b0);
        EX_SUB  = mk(S_EXEC_R,    10'b0000000001, 2'd0, 3'b110, 2'd0, 1'b0);
        EX_AND  = mk(S_EXEC_R,    10'b0000000001, 2'd0, 3'b000, 2'd0, 1'b0);
        EX_ORR  = mk(S_EXEC_R,    10'b0000000001, 2'd0, 3'b001, 2'd0, 1'b0);
        EX_MOVK = mk(S_EXEC_R,    10'b0000000001, 2'd2, 3'b111, 2'd0, 1'b0);
        EA_LD   = mk(S_EXEC_ADDR, 10'b0000000001, 2'd2, 3'b101, 2'd0, 1'b0);
        EA_ST   = mk(S_EXEC_ADDR, 10'b0000000011, 2'd2, 3'b101, 2'd0, 1'b0);
        MRD     = mk(S_MEM_RD,    10'b1101000000, 2'd0, 3'b000, 2'd0, 1'b0);
        MWR     = mk(S_MEM_WR,    10'b1011000000, 2'd0, 3'b000, 2'd0, 1'b0);
        WBA     = mk(S_WB_ALU,    10'b0000001000, 2'd0, 3'b000, 2'd0, 1'b0);
        WBM     = mk(S_WB_MEM,    10'b0000001100, 2'd0, 3'b000, 2'd0, 1'b0);
        BR_B    = mk(S_BRANCH,    10'b0000010000, 2'd0, 3'b000, 2'd1, 1'b0);
        BR_CT   = mk(S_BRANCH,    10'b0000010011, 2'd0, 3'b100, 2'd1, 1'b0);
        BR_CN   = mk(S_BRANCH,    10'b0000000011, 2'd0, 3'b100, 2'd1, 1'b0);
        TRP     = mk(S_TRAP,      10'b0000000000, 2'd0, 3'b000, 2'd0, 1'b1);

        add("idle",     I_ADD, 1, 0, IDLE0);
        add("add_f",    I_ADD, 1, 0, FET_R);
        add("add_d",    I_ADD, 1, 0, DEC);
        add("add_x",    I_ADD, 1, 0, EX_ADD);
        add("add_wb",   I_ADD, 1, 0, WBA);
        add("movk_f",   I_MOVK, 1, 0, FET_R);
        add("movk_d",   I_MOVK, 1, 0, DEC);
        add("movk_x",   I_MOVK, 1, 0, EX_MOVK);
        add("movk_wb",  I_MOVK, 1, 0, WBA);
        add("ld_f",     I_LDUR, 1, 0, FET_R);
        add("ld_d",     I_LDUR, 1, 0, DEC);
        add("ld_a",     I_LDUR, 1, 0, EA_LD);
        for (int k = 0; k < 3; k++)
            add("ld_wait", I_LDUR, 0, 0, MRD);
        add("ld_rdy",   I_LDUR, 1, 0, MRD);
        add("ld_wb",    I_LDUR, 1, 0, WBM);
        add("st_f",     I_STUR, 1, 0, FET_R);
        add("st_d",     I_STUR, 1, 0, DEC);
        add("st_a",     I_STUR, 1, 0, EA_ST);
        add("st_m",     I_STUR, 1, 0, MWR);
        add("b_f",      I_B, 1, 0, FET_R);
        add("b_d",      I_B, 1, 0, DEC);
        add("b_br",     I_B, 1, 0, BR_B);
        add("cbz_f",    I_CBZ, 1, 1, FET_R);
        add("cbz_d",    I_CBZ, 1, 1, DEC);
        add("cbz_z1",   I_CBZ, 1, 1, BR_CT);
        add("cbnz_f",   I_CBNZ, 1, 1, FET_R);
        add("cbnz_d",   I_CBNZ, 1, 1, DEC);
        add("cbnz_z1",  I_CBNZ, 1, 1, BR_CN);
        add("cbz_f",    I_CBZ, 1, 0, FET_R);
        add("cbz_d",    I_CBZ, 1, 0, DEC);
        add("cbz_z0",   I_CBZ, 1, 0, BR_CN);
        add("cbnz_f",   I_CBNZ, 1, 0, FET_R);
        add("cbnz_d",   I_CBNZ, 1, 0, DEC);
        add("cbnz_z0",  I_CBNZ, 1, 0, BR_CT);
        add("sub_fw",   I_SUB, 0, 0, FET_W);
        add("sub_fw",   I_SUB, 0, 0, FET_W);
        add("sub_f",    I_SUB, 1, 0, FET_R);
        add("sub_d",    I_SUB, 1, 0, DEC);
        add("sub_x",    I_SUB, 1, 0, EX_SUB);
        add("sub_wb",   I_SUB, 1, 0, WBA);
        for (int k = 0; k < 3; k++)
            add("orr_fw", I_ORR, 0, 0, FET_W);
        add("orr_last", I_ORR, 1, 0, FET_R);
        add("orr_d",    I_ORR, 1, 0, DEC);
        add("orr_x",    I_ORR, 1, 0, EX_ORR);
        add("orr_wb",   I_ORR, 1, 0, WBA);
        add("and_f",    I_AND, 1, 0, FET_R);
        add("and_d",    I_AND, 1, 0, DEC);
        add("and_x",    I_AND, 1, 0, EX_AND);
        add("and_wb",   I_AND, 1, 0, WBA);
        add("st2_f",    I_STUR, 1, 0, FET_R);
        add("st2_d",    I_STUR, 1, 0, DEC);
        add("st2_a",    I_STUR, 1, 0, EA_ST);
        for (int k = 0; k < 3; k++)
            add("st2_wait", I_STUR, 0, 0, MWR);
        add("st2_rdy",  I_STUR, 1, 0, MWR);
        add("bad_f",    I_BAD, 1, 0, FET_R);
        add("bad_d",    I_BAD, 1, 0, DEC);
        for (int k = 0; k < 20; k++)
            add("bad_trap", I_BAD, k[0], k[1], TRP);

        do_reset();
        foreach (vecs[k])
            step($sformatf("%s[%0d]", vecs[k].tag, k),
                 vecs[k].instr, vecs[k].rdy, vecs[k].z, vecs[k].exp);

        // fetch never answered: trap on the fourth wait cycle
        do_reset();
        step("to_idle", I_ADD, 0, 0, IDLE0);
        for (int k = 0; k < 4; k++)
            step($sformatf("to_wait%0d", k), I_ADD, 0, 0, FET_W);
        step("to_trap", I_ADD, 0, 0, TRP);
        step("to_stay", I_ADD, 1, 0, TRP);

        // asynchronous reset in the middle of a store
        do_reset();
        step("ar_idle", I_STUR, 1, 0, IDLE0);
        step("ar_f",    I_STUR, 1, 0, FET_R);
        step("ar_d",    I_STUR, 1, 0, DEC);
        step("ar_a",    I_STUR, 1, 0, EA_ST);
        step("ar_m0",   I_STUR, 0, 0, MWR);
        mif.mem_ready = 1'b0;
        #2;
        check("ar_pre", MWR);
        rst_n = 1'b0;
        #1;
        check("ar_async", IDLE0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step("ar_rel_idle",  I_STUR, 0, 0, IDLE0);
        step("ar_rel_fetch", I_STUR, 0, 0, FET_W);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
